// File: rtl/hmem_arbiter.sv
// Merges icache (port 0) and dcache (port 1) onto one higher-memory port, granting whole lines round-robin.
// Grant lands one cycle after valid is seen idle; request fields and fulfilled pass through with no added cycles.
module hmem_arbiter #(
    parameter int XLEN           = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            c0_req_valid,
    input  logic            c0_req_operation,
    input  logic [1:0]      c0_req_size,
    input  logic [XLEN-1:0] c0_req_address,
    input  logic [XLEN-1:0] c0_req_store_word,
    output logic [XLEN-1:0] c0_req_loaded_word,
    output logic            c0_req_fulfilled,

    input  logic            c1_req_valid,
    input  logic            c1_req_operation,
    input  logic [1:0]      c1_req_size,
    input  logic [XLEN-1:0] c1_req_address,
    input  logic [XLEN-1:0] c1_req_store_word,
    output logic [XLEN-1:0] c1_req_loaded_word,
    output logic            c1_req_fulfilled,

    output logic            mem_req_valid,
    output logic            mem_req_operation,
    output logic [1:0]      mem_req_size,
    output logic [XLEN-1:0] mem_req_address,
    output logic [XLEN-1:0] mem_req_store_word,
    input  logic [XLEN-1:0] mem_req_loaded_word,
    input  logic            mem_req_fulfilled,

    output logic [1:0]      grant
);

    localparam int BW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);

    generate
        if (XLEN != 32) begin : g_bad_xlen
            $error("hmem_arbiter: only XLEN=32 is supported");
        end
        if (WORDS_PER_LINE < 2 || (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0) begin : g_bad_wpl
            $error("hmem_arbiter: WORDS_PER_LINE must be a power of 2 and >= 2");
        end
    endgenerate

    // State encoding doubles as the one-hot grant vector {c1,c0}.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q,  beat_d;
    logic          last_q,  last_d;

    logic cur_vld;
    logic oth_vld;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        cur_vld = (state_q == GRANT1) ? c1_req_valid : c0_req_valid;
        oth_vld = (state_q == GRANT1) ? c0_req_valid : c1_req_valid;

        unique case (state_q)
            IDLE: begin
                if (c0_req_valid && (!c1_req_valid || last_q)) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                end else if (c1_req_valid) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (mem_req_fulfilled) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        // Line done: the waiting port goes first, else a same-port follow-on.
                        if (oth_vld) begin
                            state_d = (state_q == GRANT1) ? GRANT0 : GRANT1;
                            last_d  = (state_q == GRANT0);
                        end else if (cur_vld) begin
                            last_d  = (state_q == GRANT1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (!cur_vld) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_operation  = 1'b0;
        mem_req_size       = 2'b00;
        mem_req_address    = '0;
        mem_req_store_word = '0;
        c0_req_fulfilled   = 1'b0;
        c1_req_fulfilled   = 1'b0;

        unique case (state_q)
            GRANT0: begin
                mem_req_valid      = c0_req_valid;
                mem_req_operation  = c0_req_operation;
                mem_req_size       = c0_req_size;
                mem_req_address    = c0_req_address;
                mem_req_store_word = c0_req_store_word;
                c0_req_fulfilled   = mem_req_fulfilled;
            end
            GRANT1: begin
                mem_req_valid      = c1_req_valid;
                mem_req_operation  = c1_req_operation;
                mem_req_size       = c1_req_size;
                mem_req_address    = c1_req_address;
                mem_req_store_word = c1_req_store_word;
                c1_req_fulfilled   = mem_req_fulfilled;
            end
            default: ;
        endcase
    end

    // Load data is broadcast; each cache qualifies it with its own fulfilled.
    assign c0_req_loaded_word = mem_req_loaded_word;
    assign c1_req_loaded_word = mem_req_loaded_word;
    assign grant              = state_q;

endmodule

// File: tb/tb_hmem_arbiter.sv
// Directed bench for hmem_arbiter: grant timing, line handoff, regrant, abort, contention, mid-line reset.
module tb_hmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        c0_req_valid, c0_req_operation;
    logic [1:0]  c0_req_size;
    logic [31:0] c0_req_address, c0_req_store_word, c0_req_loaded_word;
    logic        c0_req_fulfilled;
    logic        c1_req_valid, c1_req_operation;
    logic [1:0]  c1_req_size;
    logic [31:0] c1_req_address, c1_req_store_word, c1_req_loaded_word;
    logic        c1_req_fulfilled;
    logic        mem_req_valid, mem_req_operation;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_address, mem_req_store_word, mem_req_loaded_word;
    logic        mem_req_fulfilled;
    logic [1:0]  grant;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    hmem_arbiter #(.XLEN(32), .WORDS_PER_LINE(8)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .c0_req_valid       (c0_req_valid),
        .c0_req_operation   (c0_req_operation),
        .c0_req_size        (c0_req_size),
        .c0_req_address     (c0_req_address),
        .c0_req_store_word  (c0_req_store_word),
        .c0_req_loaded_word (c0_req_loaded_word),
        .c0_req_fulfilled   (c0_req_fulfilled),
        .c1_req_valid       (c1_req_valid),
        .c1_req_operation   (c1_req_operation),
        .c1_req_size        (c1_req_size),
        .c1_req_address     (c1_req_address),
        .c1_req_store_word  (c1_req_store_word),
        .c1_req_loaded_word (c1_req_loaded_word),
        .c1_req_fulfilled   (c1_req_fulfilled),
        .mem_req_valid      (mem_req_valid),
        .mem_req_operation  (mem_req_operation),
        .mem_req_size       (mem_req_size),
        .mem_req_address    (mem_req_address),
        .mem_req_store_word (mem_req_store_word),
        .mem_req_loaded_word(mem_req_loaded_word),
        .mem_req_fulfilled  (mem_req_fulfilled),
        .grant              (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n           = 1'b0;
        c0_req_valid      = 1'b0;
        c1_req_valid      = 1'b0;
        mem_req_fulfilled = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // n consecutive beats on the granted port; optionally the requester drops valid with the last one.
    task automatic line(input int port, input int n, input bit drop_last);
        logic [31:0] data;
        for (int i = 0; i < n; i++) begin
            data                = 32'hA000_0000 + 32'(port * 256 + i);
            mem_req_loaded_word = data;
            mem_req_fulfilled   = 1'b1;
            if (drop_last && i == n - 1) begin
                if (port == 0) c0_req_valid = 1'b0;
                else           c1_req_valid = 1'b0;
            end
            #1;
            chk("line_grant", {30'd0, grant}, (port == 1) ? 32'd2 : 32'd1);
            if (i == 0)
                chk("line_addr", mem_req_address, (port == 1) ? c1_req_address : c0_req_address);
            if (port == 0) begin
                chk("line_c0_ful", {31'd0, c0_req_fulfilled}, 32'd1);
                chk("line_c1_ful", {31'd0, c1_req_fulfilled}, 32'd0);
                chk("line_c0_data", c0_req_loaded_word, data);
            end else begin
                chk("line_c1_ful", {31'd0, c1_req_fulfilled}, 32'd1);
                chk("line_c0_ful", {31'd0, c0_req_fulfilled}, 32'd0);
                chk("line_c1_data", c1_req_loaded_word, data);
            end
            tick();
            mem_req_fulfilled = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        c0_req_operation    = 1'b0;
        c0_req_size         = 2'd2;
        c0_req_address      = 32'h100;
        c0_req_store_word   = 32'h0;
        c1_req_operation    = 1'b0;
        c1_req_size         = 2'd2;
        c1_req_address      = 32'h200;
        c1_req_store_word   = 32'h0;
        mem_req_loaded_word = 32'h0;

        // Reset state, observed while reset is still asserted.
        reset_n           = 1'b0;
        c0_req_valid      = 1'b0;
        c1_req_valid      = 1'b0;
        mem_req_fulfilled = 1'b0;
        tick();
        tick();
        chk("rst_grant",  {30'd0, grant}, 32'd0);
        chk("rst_mvld",   {31'd0, mem_req_valid}, 32'd0);
        chk("rst_maddr",  mem_req_address, 32'd0);
        chk("rst_c0ful",  {31'd0, c0_req_fulfilled}, 32'd0);
        reset_n = 1'b1;

        // Single c0 load line.
        c0_req_valid = 1'b1;
        #1;
        chk("t1_idle_grant", {30'd0, grant}, 32'd0);
        chk("t1_idle_mvld",  {31'd0, mem_req_valid}, 32'd0);
        mem_req_fulfilled = 1'b1;
        #1;
        chk("t1_idle_ful_ignored", {31'd0, c0_req_fulfilled}, 32'd0);
        mem_req_fulfilled = 1'b0;
        tick();
        chk("t1_grant", {30'd0, grant}, 32'd1);
        chk("t1_maddr", mem_req_address, 32'h100);
        chk("t1_mvld",  {31'd0, mem_req_valid}, 32'd1);
        line(0, 8, 1'b1);
        chk("t1_release", {30'd0, grant}, 32'd0);

        // Simultaneous requests after reset: c0 first, then c1 with no bubble.
        do_reset();
        c0_req_valid = 1'b1;
        c1_req_valid = 1'b1;
        tick();
        chk("t2_first", {30'd0, grant}, 32'd1);
        line(0, 8, 1'b1);
        chk("t2_handoff", {30'd0, grant}, 32'd2);
        line(1, 8, 1'b1);
        chk("t2_release", {30'd0, grant}, 32'd0);

        // c1 store line then c1 load line, regranted back-to-back.
        c1_req_operation  = 1'b1;
        c1_req_store_word = 32'hDEADBEEF;
        c1_req_valid      = 1'b1;
        tick();
        chk("t3_grant", {30'd0, grant}, 32'd2);
        chk("t3_op_st", {31'd0, mem_req_operation}, 32'd1);
        chk("t3_sword", mem_req_store_word, 32'hDEADBEEF);
        line(1, 8, 1'b0);
        chk("t3_regrant", {30'd0, grant}, 32'd2);
        c1_req_operation = 1'b0;
        #1;
        chk("t3_op_ld", {31'd0, mem_req_operation}, 32'd0);
        line(1, 8, 1'b1);
        chk("t3_release", {30'd0, grant}, 32'd0);

        // c1 aborts after 3 beats; a following c0 line still needs all 8.
        c1_req_valid = 1'b1;
        tick();
        chk("t4_grant", {30'd0, grant}, 32'd2);
        line(1, 3, 1'b0);
        c1_req_valid = 1'b0;
        tick();
        chk("t4_abort", {30'd0, grant}, 32'd0);
        c0_req_valid = 1'b1;
        tick();
        chk("t4_c0_grant", {30'd0, grant}, 32'd1);
        line(0, 8, 1'b1);
        chk("t4_release", {30'd0, grant}, 32'd0);

        // Held contention over 4 lines alternates ports.
        do_reset();
        c0_req_valid = 1'b1;
        c1_req_valid = 1'b1;
        tick();
        chk("t5_l1", {30'd0, grant}, 32'd1);
        line(0, 8, 1'b0);
        chk("t5_l2", {30'd0, grant}, 32'd2);
        line(1, 8, 1'b0);
        chk("t5_l3", {30'd0, grant}, 32'd1);
        line(0, 8, 1'b0);
        chk("t5_l4", {30'd0, grant}, 32'd2);
        line(1, 8, 1'b0);
        chk("t5_after", {30'd0, grant}, 32'd1);
        c0_req_valid = 1'b0;
        c1_req_valid = 1'b0;
        tick();
        chk("t5_idle", {30'd0, grant}, 32'd0);

        // Reset during beat 5 of a c0 line.
        c0_req_valid = 1'b1;
        tick();
        chk("t6_grant", {30'd0, grant}, 32'd1);
        line(0, 4, 1'b0);
        mem_req_fulfilled = 1'b1;
        reset_n           = 1'b0;
        tick();
        mem_req_fulfilled = 1'b0;
        chk("t6_rst_grant", {30'd0, grant}, 32'd0);
        chk("t6_rst_mvld",  {31'd0, mem_req_valid}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("t6_regrant", {30'd0, grant}, 32'd1);
        line(0, 8, 1'b1);
        chk("t6_release", {30'd0, grant}, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
